tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//  Time-division 1:N demultiplexer; receive end of the mux-based TDM serial link.
//  Takes one serial bit per slot strobe and routes it to channel slot_idx.
//  Holds each completed frame in a parallel output register.
//  Sits after the link front end and feeds per-channel parallel consumers.
// PARAMETERS
//  N_CH   8  channels (slots) per frame; range 2..16
//  SEL_W  3  slot index width; equals clog2(N_CH)
// PORTS
//  clk          in   1      single clock, all logic on rising edge
//  rst_n        in   1      asynchronous, active-low reset; synchronous deassertion by system
//  din          in   1      serial data bit; sampled only when din_en=1
//  din_en       in   1      slot strobe: one slot per cycle with din_en=1
//  frame_sync   in   1      qualified by din_en; marks the current bit as slot 0
//  dout         out  N_CH   last complete frame, bit k = slot k; registered
//  frame_valid  out  1      1-cycle pulse: dout updated this cycle
//  slot_idx     out  SEL_W  slot that the next din_en will fill; registered
//  sync_err     out  1      1-cycle pulse on framing violation
//  locked       out  1      1 while in RUN
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, dout=0, shadow=0, slot_idx=0.
//   frame_valid=0, sync_err=0, locked=0.
//  Capture: on a din_en edge, shadow[slot_idx] <= din via a one-hot slot decode.
//   All other shadow bits hold.
//  FSM states: IDLE, RUN.
//   IDLE: din_en without frame_sync is ignored; shadow and slot_idx are unchanged.
//   IDLE: din_en with frame_sync captures slot 0, sets slot_idx=1, moves to RUN.
//   RUN, din_en, no frame_sync, slot_idx!=0: capture the bit; slot_idx+1.
//   RUN, din_en at slot_idx=N_CH-1: capture the bit; slot_idx wraps to 0.
//    Same edge: dout <= shadow with the new bit merged at bit N_CH-1.
//    frame_valid=1 in the following cycle, so it is seen with the new dout.
//    Latency from the last slot strobe to dout/frame_valid: 1 clk.
//   RUN, din_en with frame_sync at slot_idx=0: normal frame start.
//    Capture slot 0; slot_idx=1.
//   RUN, din_en with frame_sync at slot_idx!=0 (early sync):
//    sync_err pulses; the partial frame is dropped and dout holds.
//    The bit is captured as slot 0; slot_idx=1; stay in RUN (resync).
//   RUN, din_en without frame_sync at slot_idx=0 (missing sync):
//    sync_err pulses; the bit is discarded; move to IDLE.
//  frame_sync with din_en=0 has no effect in any state.
//  Between strobes (din_en=0), all state holds; gaps of any length are legal.
//  frame_valid and sync_err are never 1 in the same cycle.
//   A frame completes only at the last slot; errors occur only at sync events.
//  Reset mid-frame: the partial frame is lost; dout clears to 0 immediately.
//  locked = (state==RUN). slot_idx is valid only when locked=1.
//  slot_idx never exceeds N_CH-1.
//   It is a modulo-N_CH counter, not a free-running SEL_W wrap.
// STRUCTURE
//  Shared package (tdm_pkg), also used by the TDM transmitter:
//   - state encoding: ST_IDLE=1'b0, ST_RUN=1'b1.
//   - default N_CH and SEL_W.
//  Sub-module slot_dec (SEL_W -> N_CH one-hot decoder, combinational, gated by en).
//   It drives the shadow-register bit enables.
//   It is the inverse of the 2:1 mux tree on the transmit side.
//  Top level holds the FSM, slot counter, shadow register, and output register.
// TESTING (N_CH=8)
//  1. Reset, then strobe 8 slots, sync on slot 0, bits 1,0,1,1,0,0,1,0.
//     -> dout=8'h4D and frame_valid pulses once, 1 clk after the 8th strobe.
//  2. 3 back-to-back frames 8'hFF, 8'h00, 8'hA5 with din_en held high.
//     -> frame_valid at cycles 9, 17, 25 with the matching dout; sync_err never 1.
//  3. Sync, 4 slots, then a sync again on the 5th strobe.
//     -> sync_err pulses; dout unchanged; slot_idx=1.
//     -> Then 7 more strobes complete the frame normally.
//  4. Complete a frame, then the next strobe arrives without sync.
//     -> sync_err pulses; locked=0; the following 10 strobes without sync do not change dout.
//  5. Insert random din_en gaps of 0..5 cycles inside a frame (value 8'h3C).
//     -> dout=8'h3C; slot_idx holds during the gaps.
//  6. Assert rst_n=0 asynchronously mid-frame, at slot 5.
//     -> dout, frame_valid, and locked are 0 before the next clk edge.
//     -> After release, a full frame is required before frame_valid.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared TDM link definitions: frame-lock state encoding and default frame geometry.
// Used by both the transmit mux and the receive demux.
package tdm_pkg;

    localparam int N_CH_DEF  = 8;
    localparam int SEL_W_DEF = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tdm_state_t;

endpackage : tdm_pkg

// File: rtl/tdm_demux_slot_dec.sv
// Slot index to one-hot bit-enable decoder for the receive shadow register.
// Mirrors the transmit-side mux tree: exactly one enable per captured slot.
module slot_dec #(
    parameter int N_CH  = tdm_pkg::N_CH_DEF,
    parameter int SEL_W = tdm_pkg::SEL_W_DEF
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [N_CH-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int k = 0; k < N_CH; k++) begin
            onehot[k] = en && (sel == SEL_W'(k));
        end
    end

endmodule : slot_dec

// File: rtl/tdm_demux.sv
// Receive end of the TDM serial link: routes one bit per slot strobe into a shadow
// register and publishes each completed frame on dout with a one-cycle frame_valid.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_en,
    input  logic             frame_sync,
    output logic [N_CH-1:0]  dout,
    output logic             frame_valid,
    output logic [SEL_W-1:0] slot_idx,
    output logic             sync_err,
    output logic             locked
);

    localparam logic [SEL_W-1:0] SLOT_LAST = SEL_W'(N_CH - 1);

    tdm_state_t       state;
    tdm_state_t       state_nxt;
    logic [SEL_W-1:0] slot_nxt;
    logic [SEL_W-1:0] cap_sel;
    logic             cap_en;
    logic             frame_done;
    logic             err_nxt;
    logic [N_CH-1:0]  cap_onehot;
    logic [N_CH-1:0]  shadow;
    logic [N_CH-1:0]  shadow_nxt;

    // Valid/ready is not used here: din_en is a pure strobe, one slot per asserted cycle,
    // and frame_sync is meaningful only in a cycle where din_en is also high.

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        slot_nxt   = slot_idx;
        cap_en     = 1'b0;
        cap_sel    = slot_idx;
        frame_done = 1'b0;
        err_nxt    = 1'b0;
        if (din_en) begin
            case (state)
                ST_IDLE: begin
                    if (frame_sync) begin
                        cap_en    = 1'b1;
                        cap_sel   = '0;
                        slot_nxt  = SEL_W'(1);
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (frame_sync) begin
                        // Sync always restarts at slot 0; mid-frame sync drops the partial frame.
                        cap_en   = 1'b1;
                        cap_sel  = '0;
                        slot_nxt = SEL_W'(1);
                        err_nxt  = (slot_idx != '0);
                    end else if (slot_idx == '0) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        cap_en = 1'b1;
                        if (slot_idx == SLOT_LAST) begin
                            slot_nxt   = '0;
                            frame_done = 1'b1;
                        end else begin
                            slot_nxt = slot_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    slot_dec #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_slot_dec (
        .sel    (cap_sel),
        .en     (cap_en),
        .onehot (cap_onehot)
    );

    assign shadow_nxt = (shadow & ~cap_onehot) | (cap_onehot & {N_CH{din}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            dout        <= '0;
            slot_idx    <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            shadow      <= shadow_nxt;
            slot_idx    <= slot_nxt;
            frame_valid <= frame_done;
            sync_err    <= err_nxt;
            // The last slot's bit is merged on the same edge it is captured.
            if (frame_done) begin
                dout <= shadow_nxt;
            end
        end
    end

    assign locked = (state == ST_RUN);

endmodule : tdm_demux

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (N_CH=8): vector table for framing sequences,
// hand-written sequences for strobe gaps and asynchronous reset mid-frame.
module tb_tdm_demux;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       din_en;
    logic       frame_sync;
    logic [7:0] dout;
    logic       frame_valid;
    logic [2:0] slot_idx;
    logic       sync_err;
    logic       locked;

    int checks;
    int errors;

    typedef struct {
        logic       en;
        logic       fs;
        logic       d;
        logic [7:0] exp_dout;
        logic       exp_fv;
        logic       exp_err;
        logic       exp_lk;
        logic [2:0] exp_slot;
        string      name;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] model_dout;

    tdm_demux #(
        .N_CH  (8),
        .SEL_W (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_en      (din_en),
        .frame_sync  (frame_sync),
        .dout        (dout),
        .frame_valid (frame_valid),
        .slot_idx    (slot_idx),
        .sync_err    (sync_err),
        .locked      (locked)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] e_dout, input logic e_fv,
                             input logic e_err, input logic e_lk, input logic [2:0] e_slot);
        check({name, ".dout"}, {24'd0, dout}, {24'd0, e_dout});
        check({name, ".frame_valid"}, {31'd0, frame_valid}, {31'd0, e_fv});
        check({name, ".sync_err"}, {31'd0, sync_err}, {31'd0, e_err});
        check({name, ".locked"}, {31'd0, locked}, {31'd0, e_lk});
        if (e_lk) begin
            check({name, ".slot_idx"}, {29'd0, slot_idx}, {29'd0, e_slot});
        end
    endtask

    // driver: inputs set at negedge, outputs sampled 1 ns after the rising edge
    task automatic drive(input logic en, input logic fs, input logic d);
        @(negedge clk);
        din_en     = en;
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic en, input logic fs, input logic d, input logic [7:0] e_dout,
                           input logic e_fv, input logic e_err, input logic e_lk,
                           input logic [2:0] e_slot, input string name);
        vec_t v;
        v.en = en; v.fs = fs; v.d = d; v.exp_dout = e_dout; v.exp_fv = e_fv;
        v.exp_err = e_err; v.exp_lk = e_lk; v.exp_slot = e_slot; v.name = name;
        vecs.push_back(v);
    endtask

    // Full locked frame from slot 0; dout and frame_valid change only after slot 7.
    task automatic add_frame(input logic [7:0] val, input string name);
        for (int k = 0; k < 8; k++) begin
            add_vec(1'b1, (k == 0), val[k], (k == 7) ? val : model_dout, (k == 7), 1'b0, 1'b1,
                    3'((k + 1) % 8), $sformatf("%s.s%0d", name, k));
        end
        model_dout = val;
    endtask

    initial begin
        logic [7:0] v3;
        logic [7:0] v5;
        logic [7:0] v6;
        int         gap;
        checks     = 0;
        errors     = 0;
        model_dout = 8'h00;
        din        = 1'b0;
        din_en     = 1'b0;
        frame_sync = 1'b0;
        rst_n      = 1'b0;
        #12;
        check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
        check("reset.slot_idx", {29'd0, slot_idx}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single frame 4D, then one idle cycle so frame_valid is seen to drop
        add_frame(8'h4D, "t1");
        add_vec(1'b0, 1'b0, 1'b0, 8'h4D, 1'b0, 1'b0, 1'b1, 3'd0, "t1.idle");
        // 2: back-to-back frames with din_en held high
        add_frame(8'hFF, "t2a");
        add_frame(8'h00, "t2b");
        add_frame(8'hA5, "t2c");
        // 3: early sync on the 5th strobe, then resync completes frame 96
        v3 = 8'h96;
        add_vec(1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 3'd1, "t3.s0");
        for (int k = 1; k < 4; k++)
            add_vec(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 3'(k + 1), $sformatf("t3.s%0d", k));
        add_vec(1'b1, 1'b1, v3[0], 8'hA5, 1'b0, 1'b1, 1'b1, 3'd1, "t3.early");
        for (int k = 1; k < 8; k++)
            add_vec(1'b1, 1'b0, v3[k], (k == 7) ? v3 : 8'hA5, (k == 7), 1'b0, 1'b1,
                    3'((k + 1) % 8), $sformatf("t3.r%0d", k));
        // 4: missing sync drops lock; later strobes and a lone sync without strobe are ignored
        add_vec(1'b1, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1, 1'b0, 3'd0, "t4.miss");
        for (int k = 0; k < 10; k++)
            add_vec(1'b1, 1'b0, k[0], 8'h96, 1'b0, 1'b0, 1'b0, 3'd0, $sformatf("t4.ign%0d", k));
        add_vec(1'b0, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 3'd0, "t4.fs_no_en");

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].fs, vecs[i].d);
            check_all(vecs[i].name, vecs[i].exp_dout, vecs[i].exp_fv, vecs[i].exp_err,
                      vecs[i].exp_lk, vecs[i].exp_slot);
        end

        // 5: random strobe gaps inside frame 3C; slot_idx holds across each gap
        v5 = 8'h3C;
        for (int k = 0; k < 8; k++) begin
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, (g == 0), 1'b1);
                check_all($sformatf("t5.gap%0d", k), 8'h96, 1'b0, 1'b0, (k != 0), 3'(k));
            end
            drive(1'b1, (k == 0), v5[k]);
            check_all($sformatf("t5.s%0d", k), (k == 7) ? v5 : 8'h96, (k == 7), 1'b0, 1'b1,
                      3'((k + 1) % 8));
        end

        // 6: async reset while slot_idx=5
        for (int k = 0; k < 5; k++) drive(1'b1, (k == 0), 1'b1);
        check("t6.pre.slot_idx", {29'd0, slot_idx}, 32'd5);
        @(negedge clk);
        din_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_all("t6.async", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 5; k < 8; k++) begin
            drive(1'b1, 1'b0, 1'b1);
            check_all($sformatf("t6.tail%0d", k), 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
        end
        v6 = 8'h81;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, (k == 0), v6[k]);
            check_all($sformatf("t6.f%0d", k), (k == 7) ? v6 : 8'h00, (k == 7), 1'b0, 1'b1,
                      3'((k + 1) % 8));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tdm_demux
